mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 17 +
 rtl/mem_loader_byte_packer.sv | 30 +++
 rtl/mem_loader.sv | 181 ++++++++++++++++++
 tb/tb_mem_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the mem_loader slice: FSM state encoding and RAM address widths.
package mem_loader_pkg;

  localparam int unsigned INST_AW = 10;
  localparam int unsigned DATA_AW = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP_ADDR,
    DUMP_WAIT,
    DUMP_SEND,
    DONE
  } state_t;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Big-endian byte-to-word packer: the first byte of a word lands in [31:24]; word_valid pulses
// for one cycle after the fourth byte while the next word may already be shifting in.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_cnt,
  output logic        word_valid,
  output logic [31:0] word
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && (byte_cnt == 2'd3);
      if (clear) begin
        byte_cnt <= '0;
      end else if (byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        word     <= {word[23:0], byte_in};
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Loads instruction words from a byte stream, runs the CPU, then streams data RAM bytes out.
// Optional trailing checksum byte on the load stream: define MEM_LOADER_CHECKSUM_EN.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned LOAD_WORDS = 1024,
  parameter int unsigned DUMP_BYTES = 256
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               inst_ram_we,
  output logic [INST_AW-1:0] addr_inst_ram,
  output logic [31:0]        din_inst_ram,
  output logic               dump_active,
  output logic [DATA_AW-1:0] addr_data_ram,
  input  logic [7:0]         dout_data_ram,
  output logic               cpu_enable,
  input  logic               cpu_finish,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [INST_AW-1:0] LAST_WORD = INST_AW'(LOAD_WORDS - 1);
  localparam logic [16:0]        LAST_BYTE = 17'(DUMP_BYTES - 1);

  state_t              state, state_nx;
  logic [1:0]          rst_sync;
  logic                rst_n;
  logic [INST_AW-1:0]  word_idx;
  logic [16:0]         dump_idx;
  logic                payload_done;
  logic                done_q;
  logic                start_ok, rx_fire, pack_valid, tx_fire;
  logic                load_exit, load_fail;
  logic [1:0]          byte_cnt;
  logic                word_valid;
  logic [31:0]         word;

  // Assert asynchronously, release two edges after reset rises.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign start_ok   = (state == IDLE) && start;
  assign rx_fire    = rx_valid && rx_ready;
  assign pack_valid = rx_fire && !payload_done;
  assign tx_fire    = (state == DUMP_SEND) && tx_ready;

  byte_packer u_packer (
    .clk        (clk_in),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_valid (pack_valid),
    .byte_in    (rx_data),
    .byte_cnt   (byte_cnt),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_got, csum_bad, words_done, err_q;

  // The byte after the payload is the checksum; compare it against the running sum.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      csum       <= '0;
      csum_got   <= 1'b0;
      csum_bad   <= 1'b0;
      words_done <= 1'b0;
      err_q      <= 1'b0;
    end else if (start_ok) begin
      csum       <= '0;
      csum_got   <= 1'b0;
      csum_bad   <= 1'b0;
      words_done <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (pack_valid) csum <= csum + rx_data;
      if (rx_fire && payload_done) begin
        csum_got <= 1'b1;
        csum_bad <= (rx_data != csum);
      end
      if (word_valid && (word_idx == LAST_WORD)) words_done <= 1'b1;
      if ((state == LOAD) && load_fail) err_q <= 1'b1;
    end
  end

  assign rx_ready  = (state == LOAD) && !csum_got;
  assign load_exit = words_done && csum_got;
  assign load_fail = load_exit && csum_bad;
  assign error     = err_q;
`else
  assign rx_ready  = (state == LOAD) && !payload_done;
  assign load_exit = word_valid && (word_idx == LAST_WORD);
  assign load_fail = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_idx     <= '0;
      dump_idx     <= '0;
      payload_done <= 1'b0;
      tx_data      <= '0;
      done_q       <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        word_idx     <= '0;
        dump_idx     <= '0;
        payload_done <= 1'b0;
        done_q       <= 1'b0;
      end else begin
        // Counters saturate at their last value so nothing wraps within a session.
        if (word_valid && (word_idx != LAST_WORD)) word_idx <= word_idx + 1'b1;
        if (pack_valid && (byte_cnt == 2'd3) && (word_idx == LAST_WORD)) payload_done <= 1'b1;
        if (state == DUMP_WAIT) tx_data <= dout_data_ram;
        if (tx_fire && (dump_idx != LAST_BYTE)) dump_idx <= dump_idx + 1'b1;
        if (state_nx == DONE) done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    busy        = 1'b1;
    cpu_enable  = 1'b0;
    dump_active = 1'b0;
    tx_valid    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        if (load_exit) state_nx = load_fail ? DONE : RUN;
      end
      RUN: begin
        cpu_enable = !cpu_finish;
        if (cpu_finish) state_nx = DUMP_ADDR;
      end
      DUMP_ADDR: begin
        dump_active = 1'b1;
        state_nx    = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        dump_active = 1'b1;
        state_nx    = DUMP_SEND;
      end
      DUMP_SEND: begin
        dump_active = 1'b1;
        tx_valid    = 1'b1;
        if (tx_ready) state_nx = (dump_idx == LAST_BYTE) ? DONE : DUMP_ADDR;
      end
      DONE: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign done          = done_q;
  assign inst_ram_we   = word_valid;
  assign addr_inst_ram = word_idx;
  assign din_inst_ram  = word;
  assign addr_data_ram = dump_active ? dump_idx[DATA_AW-1:0] : '0;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: random load/run/dump sessions, backpressure, mid-load reset.
module tb_mem_loader;

  localparam int LW = 2;
  localparam int DB = 3;

  logic        clk_in = 1'b0;
  logic        reset, start, rx_valid, tx_ready, cpu_finish;
  logic [7:0]  rx_data, tx_data, dout_data_ram;
  logic        rx_ready, tx_valid, inst_ram_we, dump_active, cpu_enable, busy, done, error;
  logic [9:0]  addr_inst_ram;
  logic [31:0] din_inst_ram;
  logic [15:0] addr_data_ram;

  mem_loader #(.LOAD_WORDS(LW), .DUMP_BYTES(DB)) dut (
    .clk_in(clk_in), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .inst_ram_we(inst_ram_we), .addr_inst_ram(addr_inst_ram), .din_inst_ram(din_inst_ram),
    .dump_active(dump_active), .addr_data_ram(addr_data_ram), .dout_data_ram(dout_data_ram),
    .cpu_enable(cpu_enable), .cpu_finish(cpu_finish),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] data_mem [65536];
  always @(posedge clk_in) dout_data_ram <= data_mem[addr_data_ram];

  typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  wr_t        mon_w;
  logic [7:0] mon_b;
  logic       expect_run = 1'b0;
  logic [7:0] pay [LW*4];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes a word or hands over a byte.
  always @(negedge clk_in) begin
    #1;
    if (expect_run) begin
      chk("run_after_last_write", {63'd0, cpu_enable}, 64'd1);
      expect_run = 1'b0;
    end
    if (inst_ram_we) begin
      if (exp_wr.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", addr_inst_ram, din_inst_ram);
      end else begin
        mon_w = exp_wr.pop_front();
        chk("write_addr", {54'd0, addr_inst_ram}, {54'd0, mon_w.a});
        chk("write_data", {32'd0, din_inst_ram}, {32'd0, mon_w.d});
`ifndef MEM_LOADER_CHECKSUM_EN
        if (mon_w.a == 10'(LW - 1)) expect_run = 1'b1;
`endif
      end
    end
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_tx: got %0h expected none", tx_data);
      end else begin
        mon_b = exp_tx.pop_front();
        chk("tx_byte", {56'd0, tx_data}, {56'd0, mon_b});
      end
    end
  end

  task automatic start_pulse();
    @(negedge clk_in); start = 1'b1;
    @(negedge clk_in); start = 1'b0;
    chk("busy_after_start", {62'd0, busy, done}, 64'd2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk_in);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin @(negedge clk_in); n++; end
    if (n >= 50) chk("rx_ready_timeout", {63'd0, rx_ready}, 64'd1);
    @(posedge clk_in);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_wide"}, {6'd0, din_inst_ram, addr_inst_ram, addr_data_ram}, 64'd0);
    chk({name, "_narrow"}, {48'd0, tx_data, rx_ready, tx_valid, inst_ram_we, dump_active,
                            cpu_enable, busy, done, error}, 64'd0);
  endtask

  task automatic run_session(input bit bad_csum, input bit bp_first);
    int         n;
    int         hold;
    logic [7:0] sum;
    start_pulse();
    chk("rx_ready_in_load", {63'd0, rx_ready}, 64'd1);
    for (int i = 0; i < LW; i++)
      exp_wr.push_back({10'(i), pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]});
    sum = 8'd0;
    for (int i = 0; i < LW*4; i++) begin
      sum = sum + pay[i];
      if (i == 3) begin
        @(negedge clk_in); rx_valid = 1'b0; cpu_finish = 1'b1;
        @(negedge clk_in); cpu_finish = 1'b0;
        chk("finish_ignored_in_load", {62'd0, rx_ready, cpu_enable}, 64'd2);
      end
      if ($urandom_range(0, 2) == 0) begin @(negedge clk_in); rx_valid = 1'b0; end
      send_byte(pay[i]);
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? sum + 8'd1 : sum);
`endif
    @(negedge clk_in); rx_valid = 1'b0;
    if (bad_csum) begin
      n = 0;
      hold = 0;
      while (!done && n < 50) begin
        if (cpu_enable) hold++;
        @(negedge clk_in); n++;
      end
      chk("bad_csum_done", {63'd0, done}, 64'd1);
      chk("bad_csum_error", {63'd0, error}, 64'd1);
      chk("bad_csum_no_run", 64'(hold), 64'd0);
      @(negedge clk_in);
      return;
    end
    n = 0;
    while (!cpu_enable && n < 50) begin @(negedge clk_in); n++; end
    chk("enter_run", {62'd0, cpu_enable, error}, 64'd2);
    @(negedge clk_in); start = 1'b1;
    @(negedge clk_in); start = 1'b0;
    chk("start_ignored_in_run", {61'd0, cpu_enable, busy, rx_ready}, 64'd6);
    repeat ($urandom_range(0, 3)) @(negedge clk_in);
    @(negedge clk_in); cpu_finish = 1'b1;
    #1 chk("cpu_enable_drop", {62'd0, cpu_enable, dump_active}, 64'd0);
    @(negedge clk_in); cpu_finish = 1'b0;
    chk("dump_active_on", {63'd0, dump_active}, 64'd1);
    for (int k = 0; k < DB; k++) exp_tx.push_back(data_mem[k]);
    for (int k = 0; k < DB; k++) begin
      n = 0;
      while (!tx_valid && n < 20) begin @(negedge clk_in); n++; end
      if (n >= 20) chk("tx_valid_timeout", {63'd0, tx_valid}, 64'd1);
      hold = (k == 0 && bp_first) ? 5 : $urandom_range(0, 2);
      repeat (hold) begin
        chk("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, data_mem[k]});
        @(negedge clk_in);
      end
      tx_ready = 1'b1;
      @(posedge clk_in); #1 tx_ready = 1'b0;
    end
    @(negedge clk_in);
    chk("done_state", {61'd0, done, busy, dump_active}, 64'd4);
    start = 1'b1;
    @(negedge clk_in); start = 1'b0;
    chk("idle_after_done", {62'd0, done, busy}, 64'd2);
    @(negedge clk_in);
    chk("start_ignored_in_done", {62'd0, done, busy}, 64'd2);
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < LW*4; i++) pay[i] = 8'($urandom);
  endtask

  task automatic randomize_data_mem();
    for (int k = 0; k < DB; k++) data_mem[k] = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] dir_bytes [8];
    dir_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tx_ready = 1'b0; cpu_finish = 1'b0;
    #3 reset = 1'b0;
    #1 check_reset_outputs("power_on_reset");
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);

    for (int i = 0; i < LW*4; i++) pay[i] = dir_bytes[i];
    randomize_data_mem();
    data_mem[0] = 8'hA5;
    run_session(1'b0, 1'b1);

    randomize_payload();
    data_mem[0] = 8'h01; data_mem[1] = 8'h02; data_mem[2] = 8'h03;
    run_session(1'b0, 1'b0);

    randomize_payload();
    start_pulse();
    send_byte(pay[0]);
    send_byte(pay[1]);
    @(negedge clk_in); rx_valid = 1'b0; reset = 1'b0;
    #1 check_reset_outputs("mid_load_reset");
    repeat (3) @(negedge clk_in);
    check_reset_outputs("held_reset");
    reset = 1'b1; start = 1'b1;
    @(negedge clk_in); start = 1'b0;
    chk("reset_release_sync", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk_in);
    chk("idle_after_reset", {63'd0, busy}, 64'd0);

    for (int s = 0; s < 4; s++) begin
      randomize_payload();
      randomize_data_mem();
      run_session(1'b0, 1'(s == 0));
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    randomize_payload();
    run_session(1'b1, 1'b0);
    randomize_payload();
    randomize_data_mem();
    run_session(1'b0, 1'b0);
`endif
    repeat (4) @(negedge clk_in);
    chk("write_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
